// File: rtl/cc_arc_pkg.sv
// Shared definitions for the ARC microprogram sequencer.
//   - Microword field bit positions (41-bit word)
//   - COND encodings for next-address selection
//   - Sequencer FSM state encoding
//   - decode_addr(): maps IR op/op3 fields to a control-store dispatch address
package cc_arc_pkg;

  localparam int MW_W   = 41;
  localparam int ADDR_W = 11;

  // Microword field positions
  localparam int MW_A_HI    = 40;
  localparam int MW_A_LO    = 35;
  localparam int MW_AMUX    = 34;
  localparam int MW_B_HI    = 33;
  localparam int MW_B_LO    = 28;
  localparam int MW_BMUX    = 27;
  localparam int MW_C_HI    = 26;
  localparam int MW_C_LO    = 21;
  localparam int MW_CMUX    = 20;
  localparam int MW_RD      = 19;
  localparam int MW_WR      = 18;
  localparam int MW_ALU_HI  = 17;
  localparam int MW_ALU_LO  = 14;
  localparam int MW_COND_HI = 13;
  localparam int MW_COND_LO = 11;
  localparam int MW_JUMP_HI = 10;
  localparam int MW_JUMP_LO = 0;

  typedef enum logic [2:0] {
    COND_NEXT   = 3'b000,
    COND_N      = 3'b001,
    COND_Z      = 3'b010,
    COND_V      = 3'b011,
    COND_C      = 3'b100,
    COND_IR13   = 3'b101,
    COND_JUMP   = 3'b110,
    COND_DECODE = 3'b111
  } cond_t;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_EXEC    = 2'd1,
    ST_MEMWAIT = 2'd2,
    ST_PAUSE   = 2'd3
  } seq_state_t;

  // Dispatch address: 1 op op3 00. Branch/sethi (op=00) only have a
  // 3-bit sub-opcode in IR[24:22]; it lands in [8:6] with the rest zero.
  function automatic logic [ADDR_W-1:0] decode_addr(input logic [1:0] op,
                                                    input logic [5:0] op3);
    if (op == 2'b00) begin
      decode_addr = {1'b1, 1'b0, op3[5:3], 6'b000000};
    end else begin
      decode_addr = {1'b1, op, op3, 2'b00};
    end
  endfunction

endpackage

// File: rtl/cc_micro_branch_logic.sv
// Combinational next-MPC selection.
// Ports:
//   cond      in  3   COND field of the MIR
//   psr       in  4   {n,z,v,c} flags as seen at commit
//   ir_op     in  2   IR[31:30]
//   ir_op3    in  6   IR[24:19]
//   ir_bit13  in  1   IR[13] (immediate select)
//   jump      in  11  JUMP field of the MIR
//   mpc       in  11  current MPC
//   next_mpc  out 11  address to load into MPC on commit
module cc_micro_branch_logic
  import cc_arc_pkg::*;
(
  input  logic [2:0]        cond,
  input  logic [3:0]        psr,
  input  logic [1:0]        ir_op,
  input  logic [5:0]        ir_op3,
  input  logic              ir_bit13,
  input  logic [ADDR_W-1:0] jump,
  input  logic [ADDR_W-1:0] mpc,
  output logic [ADDR_W-1:0] next_mpc
);

  logic [ADDR_W-1:0] mpc_inc;
  logic              take_jump;

  // Natural 11-bit wrap: 2047 + 1 -> 0
  assign mpc_inc = mpc + ADDR_W'(1);

  always_comb begin
    take_jump = 1'b0;
    next_mpc  = mpc_inc;
    case (cond_t'(cond))
      COND_N:      take_jump = psr[3];
      COND_Z:      take_jump = psr[2];
      COND_V:      take_jump = psr[1];
      COND_C:      take_jump = psr[0];
      COND_IR13:   take_jump = ir_bit13;
      COND_JUMP:   take_jump = 1'b1;
      default:     take_jump = 1'b0;
    endcase
    if (cond_t'(cond) == COND_DECODE) begin
      next_mpc = decode_addr(ir_op, ir_op3);
    end else if (take_jump) begin
      next_mpc = jump;
    end
  end

endmodule

// File: rtl/cc_micro_sequencer.sv
// ARC microprogram sequencer: owns MPC and MIR, fetches the microword from
// the combinational control store, commits it (optionally after a memory
// handshake) and selects the next MPC.
// Ports:
//   CC_MicroSequencer_CLOCK_50         in  1   clock
//   CC_MicroSequencer_RESET_InLow      in  1   async active-low reset
//   CC_MicroSequencer_run_InLow        in  1   0 = run, 1 = pause at commit
//   CC_MicroSequencer_microword_InBUS  in  41  control-store output at MPC
//   CC_MicroSequencer_ir_InBUS         in  32  instruction register
//   CC_MicroSequencer_psr_InBUS        in  4   {n,z,v,c}
//   CC_MicroSequencer_memReady_In      in  1   memory access completes
//   CC_MicroSequencer_mpc_OutBUS       out 11  control-store address
//   CC_MicroSequencer_mir_OutBUS       out 41  MIR to datapath
//   CC_MicroSequencer_execute_Out      out 1   datapath commit strobe
//   CC_MicroSequencer_memRd_Out        out 1   memory read request
//   CC_MicroSequencer_memWr_Out        out 1   memory write request
//   CC_MicroSequencer_state_OutBUS     out 2   FSM state (debug)
module cc_micro_sequencer
  import cc_arc_pkg::*;
#(
  parameter int DATAWIDTH_MICROWORD = MW_W,
  parameter int DATAWIDTH_ADDR      = ADDR_W,
  parameter int RESET_ADDR          = 0
) (
  input  logic                           CC_MicroSequencer_CLOCK_50,
  input  logic                           CC_MicroSequencer_RESET_InLow,
  input  logic                           CC_MicroSequencer_run_InLow,
  input  logic [DATAWIDTH_MICROWORD-1:0] CC_MicroSequencer_microword_InBUS,
  input  logic [31:0]                    CC_MicroSequencer_ir_InBUS,
  input  logic [3:0]                     CC_MicroSequencer_psr_InBUS,
  input  logic                           CC_MicroSequencer_memReady_In,
  output logic [DATAWIDTH_ADDR-1:0]      CC_MicroSequencer_mpc_OutBUS,
  output logic [DATAWIDTH_MICROWORD-1:0] CC_MicroSequencer_mir_OutBUS,
  output logic                           CC_MicroSequencer_execute_Out,
  output logic                           CC_MicroSequencer_memRd_Out,
  output logic                           CC_MicroSequencer_memWr_Out,
  output logic [1:0]                     CC_MicroSequencer_state_OutBUS
);

  localparam logic [DATAWIDTH_ADDR-1:0] RESET_MPC = DATAWIDTH_ADDR'(RESET_ADDR);

  seq_state_t                     state_reg, state_next;
  logic [DATAWIDTH_ADDR-1:0]      mpc_reg, mpc_next;
  logic [DATAWIDTH_MICROWORD-1:0] mir_reg, mir_next;
  logic [DATAWIDTH_ADDR-1:0]      branch_mpc;
  logic                           mir_rd, mir_wr, mem_req;
  logic                           execute, mem_rd, mem_wr;

  assign mir_rd  = mir_reg[MW_RD];
  assign mir_wr  = mir_reg[MW_WR];
  assign mem_req = mir_rd | mir_wr;

  cc_micro_branch_logic u_branch (
    .cond     (mir_reg[MW_COND_HI:MW_COND_LO]),
    .psr      (CC_MicroSequencer_psr_InBUS),
    .ir_op    (CC_MicroSequencer_ir_InBUS[31:30]),
    .ir_op3   (CC_MicroSequencer_ir_InBUS[24:19]),
    .ir_bit13 (CC_MicroSequencer_ir_InBUS[13]),
    .jump     (mir_reg[MW_JUMP_HI:MW_JUMP_LO]),
    .mpc      (mpc_reg),
    .next_mpc (branch_mpc)
  );

  always_ff @(posedge CC_MicroSequencer_CLOCK_50 or negedge CC_MicroSequencer_RESET_InLow) begin
    if (!CC_MicroSequencer_RESET_InLow) begin
      state_reg <= ST_FETCH;
      mpc_reg   <= RESET_MPC;
      mir_reg   <= '0;
    end else begin
      state_reg <= state_next;
      mpc_reg   <= mpc_next;
      mir_reg   <= mir_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    mpc_next   = mpc_reg;
    mir_next   = mir_reg;
    execute    = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    case (state_reg)
      ST_FETCH: begin
        mir_next   = CC_MicroSequencer_microword_InBUS;
        state_next = ST_EXEC;
      end
      ST_EXEC, ST_MEMWAIT: begin
        // Request is driven from EXEC onward so a ready memory can finish
        // in the same cycle the request launches.
        mem_rd = mir_rd;
        mem_wr = mir_wr;
        if (mem_req && !CC_MicroSequencer_memReady_In) begin
          state_next = ST_MEMWAIT;
        end else begin
          execute    = 1'b1;
          mpc_next   = branch_mpc;
          // run_InLow only matters at the commit boundary
          state_next = CC_MicroSequencer_run_InLow ? ST_PAUSE : ST_FETCH;
        end
      end
      ST_PAUSE: begin
        if (!CC_MicroSequencer_run_InLow) state_next = ST_FETCH;
      end
      default: state_next = ST_FETCH;
    endcase
  end

  assign CC_MicroSequencer_mpc_OutBUS   = mpc_reg;
  assign CC_MicroSequencer_mir_OutBUS   = mir_reg;
  assign CC_MicroSequencer_execute_Out  = execute;
  assign CC_MicroSequencer_memRd_Out    = mem_rd;
  assign CC_MicroSequencer_memWr_Out    = mem_wr;
  assign CC_MicroSequencer_state_OutBUS = state_reg;

endmodule

// File: tb/tb_cc_micro_sequencer.sv
// Directed bench for cc_micro_sequencer. A small control-store array in the
// bench feeds the microword for the current MPC; each scenario programs the
// words it needs and checks outputs 1 time unit after the rising edge.
module tb_cc_micro_sequencer;

  logic        clk;
  logic        rst_n;
  logic        run_n;
  logic [40:0] microword;
  logic [31:0] ir;
  logic [3:0]  psr;
  logic        mem_ready;
  logic [10:0] mpc;
  logic [40:0] mir;
  logic        execute;
  logic        mem_rd;
  logic        mem_wr;
  logic [1:0]  state;

  logic [40:0] cs [0:2047];

  int pass_cnt  = 0;
  int total_cnt = 0;

  cc_micro_sequencer dut (
    .CC_MicroSequencer_CLOCK_50        (clk),
    .CC_MicroSequencer_RESET_InLow     (rst_n),
    .CC_MicroSequencer_run_InLow       (run_n),
    .CC_MicroSequencer_microword_InBUS (microword),
    .CC_MicroSequencer_ir_InBUS        (ir),
    .CC_MicroSequencer_psr_InBUS       (psr),
    .CC_MicroSequencer_memReady_In     (mem_ready),
    .CC_MicroSequencer_mpc_OutBUS      (mpc),
    .CC_MicroSequencer_mir_OutBUS      (mir),
    .CC_MicroSequencer_execute_Out     (execute),
    .CC_MicroSequencer_memRd_Out       (mem_rd),
    .CC_MicroSequencer_memWr_Out       (mem_wr),
    .CC_MicroSequencer_state_OutBUS    (state)
  );

  assign microword = cs[mpc];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // Microword builder: A field, RD, WR, COND, JUMP (other fields zero)
  function automatic logic [40:0] mw(input logic [5:0] a, input logic rd, input logic wr,
                                     input logic [2:0] cond, input logic [10:0] jump);
    mw = {a, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, rd, wr, 4'd0, cond, jump};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Runs one non-memory microinstruction from FETCH and checks the commit.
  task automatic run_word(input logic [3:0] p, input logic [31:0] i,
                          input logic [10:0] exp_mpc, input string name);
    psr = p;
    ir  = i;
    step();
    total_cnt++;
    if (state !== 2'd1 || execute !== 1'b1)
      $display("FAIL %s_exec: got state=%0d execute=%0b want state=1 execute=1", name, state, execute);
    else pass_cnt++;
    step();
    total_cnt++;
    if (mpc !== exp_mpc || state !== 2'd0)
      $display("FAIL %s_mpc: got mpc=%0d state=%0d want mpc=%0d state=0", name, mpc, state, exp_mpc);
    else pass_cnt++;
    $display("word %s: mpc=%0d", name, mpc);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (state !== 2'd0 || mpc !== 11'd0 || mir !== 41'd0)
      $display("FAIL reset_regs: got state=%0d mpc=%0d mir=%0h want 0 0 0", state, mpc, mir);
    else pass_cnt++;
    total_cnt++;
    if (execute !== 1'b0 || mem_rd !== 1'b0 || mem_wr !== 1'b0)
      $display("FAIL reset_outs: got ex=%0b rd=%0b wr=%0b want 0 0 0", execute, mem_rd, mem_wr);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset: state=%0d mpc=%0d", state, mpc);
  endtask

  task automatic test_basic();
    int ex_cnt;
    cs[0] = mw(6'h2A, 1'b0, 1'b0, 3'b000, 11'd0);
    do_reset();
    ex_cnt = 0;
    total_cnt++;
    if (state !== 2'd0 || execute !== 1'b0)
      $display("FAIL basic_fetch: got state=%0d ex=%0b want 0 0", state, execute);
    else pass_cnt++;
    step();
    if (execute === 1'b1) ex_cnt++;
    total_cnt++;
    if (state !== 2'd1 || mir !== mw(6'h2A, 1'b0, 1'b0, 3'b000, 11'd0))
      $display("FAIL basic_exec: got state=%0d mir=%0h want 1 %0h", state, mir,
               mw(6'h2A, 1'b0, 1'b0, 3'b000, 11'd0));
    else pass_cnt++;
    step();
    if (execute === 1'b1) ex_cnt++;
    total_cnt++;
    if (mpc !== 11'd1 || state !== 2'd0)
      $display("FAIL basic_mpc: got mpc=%0d state=%0d want 1 0", mpc, state);
    else pass_cnt++;
    total_cnt++;
    if (ex_cnt != 1)
      $display("FAIL basic_expulse: got %0d pulses want 1", ex_cnt);
    else pass_cnt++;
    $display("basic: mpc=%0d execute pulses=%0d", mpc, ex_cnt);
  endtask

  task automatic test_branches();
    cs[0]    = mw(6'd0, 1'b0, 1'b0, 3'b110, 11'd10);
    cs[10]   = mw(6'd0, 1'b0, 1'b0, 3'b010, 11'd12);
    cs[12]   = mw(6'd0, 1'b0, 1'b0, 3'b110, 11'd10);
    cs[11]   = mw(6'd0, 1'b0, 1'b0, 3'b101, 11'd20);
    cs[20]   = mw(6'd0, 1'b0, 1'b0, 3'b111, 11'd0);
    cs[1600] = mw(6'd0, 1'b0, 1'b0, 3'b001, 11'd5);
    cs[1601] = mw(6'd0, 1'b0, 1'b0, 3'b100, 11'd30);
    cs[30]   = mw(6'd0, 1'b0, 1'b0, 3'b011, 11'd40);
    cs[40]   = mw(6'd0, 1'b0, 1'b0, 3'b111, 11'd0);
    cs[1152] = mw(6'd0, 1'b0, 1'b0, 3'b111, 11'd0);
    cs[1280] = mw(6'd0, 1'b0, 1'b0, 3'b001, 11'd50);
    cs[50]   = mw(6'd0, 1'b0, 1'b0, 3'b101, 11'd99);
    do_reset();
    run_word(4'b0000, 32'h0, 11'd10,   "jump");
    run_word(4'b0100, 32'h0, 11'd12,   "z_taken");
    run_word(4'b0000, 32'h0, 11'd10,   "jump_back");
    run_word(4'b1011, 32'h0, 11'd11,   "z_not_taken");
    run_word(4'b0000, 32'h0000_2000, 11'd20, "ir13_taken");
    run_word(4'b0000, 32'h8080_0000, 11'd1600, "decode_op10");
    run_word(4'b0111, 32'h0, 11'd1601, "n_not_taken");
    run_word(4'b0001, 32'h0, 11'd30,   "c_taken");
    run_word(4'b0010, 32'h0, 11'd40,   "v_taken");
    run_word(4'b0000, 32'h1280_0000, 11'd1152, "decode_op00");
    run_word(4'b0000, 32'h4000_0000, 11'd1280, "decode_op01");
    run_word(4'b1000, 32'h0, 11'd50,   "n_taken");
    run_word(4'b0000, 32'hFFFF_DFFF, 11'd51, "ir13_not_taken");
  endtask

  task automatic test_wrap_pause();
    cs[0]    = mw(6'h01, 1'b0, 1'b0, 3'b110, 11'd2047);
    cs[2047] = mw(6'h15, 1'b0, 1'b0, 3'b000, 11'd0);
    do_reset();
    run_word(4'b0000, 32'h0, 11'd2047, "to_top");
    step();
    run_n = 1'b1;
    step();
    total_cnt++;
    if (mpc !== 11'd0 || state !== 2'd3)
      $display("FAIL wrap_pause: got mpc=%0d state=%0d want 0 3", mpc, state);
    else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      step();
      total_cnt++;
      if (state !== 2'd3 || mpc !== 11'd0 || mir !== mw(6'h15, 1'b0, 1'b0, 3'b000, 11'd0) ||
          execute !== 1'b0)
        $display("FAIL pause_hold%0d: got state=%0d mpc=%0d mir=%0h ex=%0b want 3 0 %0h 0",
                 k, state, mpc, mir, execute, mw(6'h15, 1'b0, 1'b0, 3'b000, 11'd0));
      else pass_cnt++;
    end
    run_n = 1'b0;
    step();
    total_cnt++;
    if (state !== 2'd0)
      $display("FAIL pause_release: got state=%0d want 0", state);
    else pass_cnt++;
    step();
    total_cnt++;
    if (state !== 2'd1 || mir !== mw(6'h01, 1'b0, 1'b0, 3'b110, 11'd2047))
      $display("FAIL resume_fetch: got state=%0d mir=%0h want 1 %0h", state, mir,
               mw(6'h01, 1'b0, 1'b0, 3'b110, 11'd2047));
    else pass_cnt++;
    $display("wrap/pause: resumed state=%0d mpc=%0d", state, mpc);
  endtask

  task automatic test_memory();
    int rd_cnt;
    int ex_cnt;
    cs[0] = mw(6'd0, 1'b1, 1'b0, 3'b000, 11'd0);
    cs[1] = mw(6'd0, 1'b0, 1'b1, 3'b110, 11'd7);
    mem_ready = 1'b0;
    do_reset();
    rd_cnt = 0;
    ex_cnt = 0;
    step();
    for (int k = 0; k < 3; k++) begin
      total_cnt++;
      if (mem_rd !== 1'b1 || execute !== 1'b0 || mem_wr !== 1'b0)
        $display("FAIL mem_wait%0d: got rd=%0b wr=%0b ex=%0b want 1 0 0", k, mem_rd, mem_wr, execute);
      else pass_cnt++;
      if (mem_rd === 1'b1) rd_cnt++;
      if (execute === 1'b1) ex_cnt++;
      if (k < 2) step();
    end
    total_cnt++;
    if (state !== 2'd2)
      $display("FAIL mem_state: got %0d want 2", state);
    else pass_cnt++;
    #3;
    mem_ready = 1'b1;
    #1;
    total_cnt++;
    if (mem_rd !== 1'b1 || execute !== 1'b1)
      $display("FAIL mem_ready: got rd=%0b ex=%0b want 1 1", mem_rd, execute);
    else pass_cnt++;
    if (mem_rd === 1'b1) rd_cnt++;
    if (execute === 1'b1) ex_cnt++;
    step();
    mem_ready = 1'b0;
    total_cnt++;
    if (state !== 2'd0 || mpc !== 11'd1 || mem_rd !== 1'b0)
      $display("FAIL mem_done: got state=%0d mpc=%0d rd=%0b want 0 1 0", state, mpc, mem_rd);
    else pass_cnt++;
    total_cnt++;
    if (rd_cnt != 4 || ex_cnt != 1)
      $display("FAIL mem_counts: got rd=%0d ex=%0d want 4 1", rd_cnt, ex_cnt);
    else pass_cnt++;
    $display("memory read: rd cycles=%0d execute=%0d", rd_cnt, ex_cnt);
    // Write completing in the same cycle it launches
    mem_ready = 1'b1;
    step();
    total_cnt++;
    if (mem_wr !== 1'b1 || mem_rd !== 1'b0 || execute !== 1'b1)
      $display("FAIL wr_fast: got wr=%0b rd=%0b ex=%0b want 1 0 1", mem_wr, mem_rd, execute);
    else pass_cnt++;
    step();
    mem_ready = 1'b0;
    total_cnt++;
    if (mpc !== 11'd7 || state !== 2'd0)
      $display("FAIL wr_commit: got mpc=%0d state=%0d want 7 0", mpc, state);
    else pass_cnt++;
    $display("memory write: mpc=%0d", mpc);
  endtask

  task automatic test_reset_memwait();
    cs[0] = mw(6'd0, 1'b0, 1'b0, 3'b110, 11'd5);
    cs[5] = mw(6'd0, 1'b1, 1'b0, 3'b000, 11'd0);
    mem_ready = 1'b0;
    do_reset();
    run_word(4'b0000, 32'h0, 11'd5, "to_mem");
    step();
    step();
    total_cnt++;
    if (state !== 2'd2 || mem_rd !== 1'b1)
      $display("FAIL pre_reset: got state=%0d rd=%0b want 2 1", state, mem_rd);
    else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (mem_rd !== 1'b0 || mpc !== 11'd0 || state !== 2'd0 || execute !== 1'b0 || mir !== 41'd0)
      $display("FAIL async_reset: got rd=%0b mpc=%0d state=%0d ex=%0b mir=%0h want 0 0 0 0 0",
               mem_rd, mpc, state, execute, mir);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    $display("async reset in memwait: state=%0d mpc=%0d", state, mpc);
  endtask

  initial begin
    for (int a = 0; a < 2048; a++) cs[a] = 41'd0;
    rst_n     = 1'b1;
    run_n     = 1'b0;
    ir        = 32'h0;
    psr       = 4'h0;
    mem_ready = 1'b0;
    test_reset();
    test_basic();
    test_branches();
    test_wrap_pause();
    test_memory();
    test_reset_memwait();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
